// File: rtl/mdio_master_ctrl.sv
// mdio_master_ctrl -- clause-22 MDIO frame sequencer.
// Takes one register read/write request at a time, generates MDC, serialises
// the frame (preamble, ST, OP, PHYAD, REGAD, TA, DATA), releases the bus for
// the read turnaround and returns the captured data with a completion pulse.
//
// Optional feature macro: MDIO_PREAMBLE_SUPPRESS_EN
//   defined   -> adds req_nopre_i; a request with req_nopre_i=1 skips the preamble
//   undefined -> every frame carries PREAMBLE_LEN preamble bits
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o request handshake (ready only while idle)
//   req_write_i             1=write (OP 01), 0=read (OP 10)
//   req_phyad_i/req_regad_i PHY and register address
//   req_wdata_i             write data
//   req_nopre_i             suppress preamble (MDIO_PREAMBLE_SUPPRESS_EN only)
//   rsp_valid_o             one-cycle completion pulse
//   rsp_rdata_o/rsp_err_o   read data / no-PHY flag, updated on reads only
//   busy_o                  frame in progress
//   mdc_o, mdio_o, mdio_oe_o, mdio_i  MDIO pad signals
module mdio_master_ctrl #(
   parameter int unsigned CLK_DIV      = 10,
   parameter int unsigned PREAMBLE_LEN = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [4:0]  req_phyad_i,
   input  logic [4:0]  req_regad_i,
   input  logic [15:0] req_wdata_i,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   input  logic        req_nopre_i,
`endif
   output logic        rsp_valid_o,
   output logic [15:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        busy_o,
   output logic        mdc_o,
   output logic        mdio_o,
   output logic        mdio_oe_o,
   input  logic        mdio_i
);

   localparam int unsigned DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
   localparam int unsigned CNT_W = 5;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
   localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(13);
   localparam logic [CNT_W-1:0] TA_LAST  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(15);

   // Parameter legality checks at elaboration
   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("mdio_master_ctrl: CLK_DIV must be >= 2");
   end
   if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 32) begin : g_bad_preamble
      $error("mdio_master_ctrl: PREAMBLE_LEN must be in 1..32");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       tx_q, tx_d;
   logic              write_q, write_d;
   logic [15:0]       rx_q, rx_d;
   logic              ta2_q, ta2_d;
   logic              mdc_q, mdc_d;
   logic              mdio_q, mdio_d;
   logic              oe_q, oe_d;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;
   logic [15:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;

   logic nopre_c;
   logic tick_c;
   logic fall_c;
   logic samp_c;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   assign nopre_c = req_nopre_i;
`else
   assign nopre_c = 1'b0;
`endif

   // Divider terminal count, end of a bit (MDC fall) and MDIO input sample point
   assign tick_c = (div_q == DIV_LAST);
   assign fall_c = tick_c & mdc_q;
   assign samp_c = mdc_q & (div_q == '0);

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      write_d = write_q;
      rx_d    = rx_q;
      ta2_d   = ta2_q;
      mdc_d   = mdc_q;
      mdio_d  = mdio_q;
      oe_d    = oe_q;
      ready_d = ready_q;
      valid_d = 1'b0;
      rdata_d = rdata_q;
      err_d   = err_q;
      busy_d  = busy_q;

      // MDC generation runs in every bit-serial state
      if (state_q == S_PRE || state_q == S_HDR || state_q == S_TA || state_q == S_DATA) begin
         if (tick_c) begin
            div_d = '0;
            mdc_d = ~mdc_q;
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               write_d = req_write_i;
               tx_d    = {2'b01, (req_write_i ? 2'b01 : 2'b10), req_phyad_i, req_regad_i,
                          2'b10, req_wdata_i};
               div_d   = '0;
               cnt_d   = '0;
               mdc_d   = 1'b0;
               oe_d    = 1'b1;
               ready_d = 1'b0;
               busy_d  = 1'b1;
               if (nopre_c) begin
                  state_d = S_HDR;
                  mdio_d  = 1'b0;
               end else begin
                  state_d = S_PRE;
                  mdio_d  = 1'b1;
               end
            end
         end

         S_PRE: begin
            if (fall_c) begin
               if (cnt_q == PRE_LAST) begin
                  state_d = S_HDR;
                  cnt_d   = '0;
                  mdio_d  = tx_q[31];
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         S_HDR: begin
            if (fall_c) begin
               tx_d   = {tx_q[30:0], 1'b0};
               mdio_d = tx_q[30];
               if (cnt_q == HDR_LAST) begin
                  state_d = S_TA;
                  cnt_d   = '0;
                  // Reads release the bus from the first turnaround bit on
                  oe_d    = write_q;
                  mdio_d  = write_q ? tx_q[30] : 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         S_TA: begin
            if (samp_c && cnt_q == TA_LAST) begin
               ta2_d = mdio_i;
            end
            if (fall_c) begin
               tx_d   = {tx_q[30:0], 1'b0};
               mdio_d = write_q ? tx_q[30] : 1'b1;
               if (cnt_q == TA_LAST) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         S_DATA: begin
            if (samp_c) begin
               rx_d = {rx_q[14:0], mdio_i};
            end
            if (fall_c) begin
               if (cnt_q == DAT_LAST) begin
                  state_d = S_DONE;
                  cnt_d   = '0;
                  mdio_d  = 1'b1;
                  oe_d    = 1'b0;
                  valid_d = 1'b1;
                  if (!write_q) begin
                     rdata_d = rx_q;
                     err_d   = ta2_q;
                  end
               end else begin
                  tx_d   = {tx_q[30:0], 1'b0};
                  mdio_d = write_q ? tx_q[30] : 1'b1;
                  cnt_d  = cnt_q + CNT_W'(1);
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            mdc_d   = 1'b0;
            oe_d    = 1'b0;
            mdio_d  = 1'b1;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         tx_q    <= '0;
         write_q <= 1'b0;
         rx_q    <= '0;
         ta2_q   <= 1'b0;
         mdc_q   <= 1'b0;
         mdio_q  <= 1'b1;
         oe_q    <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         write_q <= write_d;
         rx_q    <= rx_d;
         ta2_q   <= ta2_d;
         mdc_q   <= mdc_d;
         mdio_q  <= mdio_d;
         oe_q    <= oe_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = valid_q;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;
   assign busy_o      = busy_q;
   assign mdc_o       = mdc_q;
   assign mdio_o      = mdio_q;
   assign mdio_oe_o   = oe_q;

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Testbench for mdio_master_ctrl: random and directed requests, expected frame
// bits and responses queued at accept time, checked by an independent monitor.
`timescale 1ns/1ps
module tb_mdio_master_ctrl;

   localparam int CD  = 2;
   localparam int PRE = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [4:0]  req_phyad = '0;
   logic [4:0]  req_regad = '0;
   logic [15:0] req_wdata = '0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   logic        req_nopre = 1'b0;
   logic        nopre_next = 1'b0;
`endif
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic        mdc;
   logic        mdio_o;
   logic        mdio_oe;
   logic        mdio_i = 1'b1;

   mdio_master_ctrl #(.CLK_DIV(CD), .PREAMBLE_LEN(PRE)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_valid_i(req_valid),
      .req_ready_o(req_ready),
      .req_write_i(req_write),
      .req_phyad_i(req_phyad),
      .req_regad_i(req_regad),
      .req_wdata_i(req_wdata),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      .req_nopre_i(req_nopre),
`endif
      .rsp_valid_o(rsp_valid),
      .rsp_rdata_o(rsp_rdata),
      .rsp_err_o  (rsp_err),
      .busy_o     (busy),
      .mdc_o      (mdc),
      .mdio_o     (mdio_o),
      .mdio_oe_o  (mdio_oe),
      .mdio_i     (mdio_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed { logic val; logic oe; } bit_t;
   typedef struct { int due; logic [15:0] rdata; logic err; } rsp_t;

   bit_t exp_bits[$];
   rsp_t exp_rsp[$];

   // Reference state describing the frame currently on the wire
   int          last_acc = -10;
   int          done_cyc = -10;
   logic        cur_write = 1'b1;
   logic        cur_present = 1'b0;
   logic [15:0] cur_rdata = '0;
   int          cur_pre = PRE;
   logic [15:0] last_rdata = '0;
   logic        last_err = 1'b0;

   int   n_vec = 0;
   int   n_err = 0;
   logic mdc_prev = 1'b0;

   // PHY: value on the wire for frame bit k (pull-up when nothing drives)
   function automatic logic phy_drive(input int k);
      int hdr_end;
      hdr_end = cur_pre + 14;
      if (cur_write) return 1'b1;
      if (k == hdr_end + 1) return cur_present ? 1'b0 : 1'b1;
      if (k >= hdr_end + 2 && k < hdr_end + 18)
         return cur_present ? cur_rdata[15 - (k - hdr_end - 2)] : 1'b1;
      return 1'b1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor and PHY model
   always @(negedge clk) begin : monitor
      logic exp_busy;
      bit_t eb;
      rsp_t er;
      if (cyc > last_acc && cyc <= done_cyc)
         mdio_i = phy_drive((cyc - last_acc - 1) / (2 * CD));
      else
         mdio_i = 1'b1;

      if (rst) begin
         chk("rst_mdc",   32'(mdc),       32'(0));
         chk("rst_mdio",  32'(mdio_o),    32'(1));
         chk("rst_oe",    32'(mdio_oe),   32'(0));
         chk("rst_ready", 32'(req_ready), 32'(1));
         chk("rst_valid", 32'(rsp_valid), 32'(0));
         chk("rst_rdata", 32'(rsp_rdata), 32'(0));
         chk("rst_err",   32'(rsp_err),   32'(0));
         chk("rst_busy",  32'(busy),      32'(0));
      end else begin
         exp_busy = (cyc > last_acc) && (cyc <= done_cyc);
         chk("busy",  32'(busy),      32'(exp_busy));
         chk("ready", 32'(req_ready), 32'(!exp_busy));
         if (!exp_busy || cyc == done_cyc)
            chk("mdc_low", 32'(mdc), 32'(0));

         if (mdc && !mdc_prev) begin
            if (exp_bits.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL mdc_rise: unexpected MDC rise at cycle %0d", cyc);
            end else begin
               eb = exp_bits.pop_front();
               chk("bit_oe", 32'(mdio_oe), 32'(eb.oe));
               if (eb.oe) chk("bit_val", 32'(mdio_o), 32'(eb.val));
            end
         end

         if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL rsp_unexpected: rsp_valid at cycle %0d", cyc);
            end else begin
               er = exp_rsp.pop_front();
               chk("rsp_cycle", 32'(cyc),       32'(er.due));
               chk("rsp_rdata", 32'(rsp_rdata), 32'(er.rdata));
               chk("rsp_err",   32'(rsp_err),   32'(er.err));
            end
         end else if (exp_rsp.size() != 0 && cyc > exp_rsp[0].due) begin
            n_vec++; n_err++;
            $display("FAIL rsp_missing: got none expected at cycle %0d", exp_rsp[0].due);
            void'(exp_rsp.pop_front());
         end
      end
      mdc_prev = mdc;
   end

   // Issue one request; returns one cycle after it is accepted
   task automatic do_req(input logic w, input logic [4:0] p, input logic [4:0] r,
                         input logic [15:0] wd, input logic present, input logic [15:0] rd);
      int   guard;
      int   pl;
      int   acc;
      bit_t b;
      rsp_t e;
      logic [13:0] hdr;
      req_write = w; req_phyad = p; req_regad = r; req_wdata = wd;
      pl = PRE;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      req_nopre = nopre_next;
      if (nopre_next) pl = 0;
`endif
      req_valid = 1'b1;
      guard = 0;
      while (!req_ready) begin
         @(negedge clk);
         guard++;
         if (guard > 2000) begin
            $display("FAIL accept_timeout: req_ready stuck at %b", req_ready);
            $fatal(1, "no accept");
         end
      end
      acc = cyc;
      for (int i = 0; i < pl; i++) begin b.val = 1'b1; b.oe = 1'b1; exp_bits.push_back(b); end
      hdr = {2'b01, (w ? 2'b01 : 2'b10), p, r};
      for (int i = 13; i >= 0; i--) begin b.val = hdr[i]; b.oe = 1'b1; exp_bits.push_back(b); end
      b.val = 1'b1; b.oe = w; exp_bits.push_back(b);
      b.val = 1'b0; b.oe = w; exp_bits.push_back(b);
      for (int i = 15; i >= 0; i--) begin b.val = wd[i]; b.oe = w; exp_bits.push_back(b); end
      if (!w) begin
         last_rdata = present ? rd : 16'hFFFF;
         last_err   = !present;
      end
      e.due = acc + 2 * (pl + 32) * CD + 1;
      e.rdata = last_rdata;
      e.err = last_err;
      exp_rsp.push_back(e);
      cur_write = w; cur_present = present; cur_rdata = rd; cur_pre = pl;
      last_acc = acc; done_cyc = e.due;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (exp_rsp.size() != 0) begin
         @(negedge clk);
         guard++;
         if (guard > 3000) begin
            $display("FAIL drain_timeout: %0d responses outstanding", exp_rsp.size());
            $fatal(1, "drain");
         end
      end
      @(negedge clk);
   endtask

   // Asynchronous reset inside bit 40 of the frame just accepted
   task automatic reset_mid();
      int target;
      target = last_acc + 1 + 2 * CD * 40;
      while (cyc != target) @(negedge clk);
      @(posedge clk);
      #2;
      done_cyc = -10;
      exp_rsp.delete();
      exp_bits.delete();
      last_rdata = '0;
      last_err = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      do_req(1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0000);
      wait_idle();
      do_req(1'b0, 5'd3, 5'd2, 16'hA5A5, 1'b1, 16'h796D);
      wait_idle();
      do_req(1'b0, 5'd7, 5'd1, 16'h0000, 1'b0, 16'h0000);
      wait_idle();
      // Held back-to-back: second is accepted as soon as the first completes
      do_req(1'b1, 5'd2, 5'd4, 16'hBEEF, 1'b0, 16'h0000);
      do_req(1'b0, 5'd2, 5'd4, 16'h0000, 1'b1, 16'h1234);
      wait_idle();
      do_req(1'b1, 5'd5, 5'd9, 16'hC3C3, 1'b0, 16'h0000);
      reset_mid();
      do_req(1'b0, 5'd5, 5'd9, 16'h0000, 1'b1, 16'h0F0F);
      wait_idle();

      repeat (14) begin
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
         nopre_next = 1'($urandom_range(0, 1));
`endif
         do_req(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 16'($urandom),
                ($urandom_range(0, 4) != 0), 16'($urandom));
         if ($urandom_range(0, 1) == 1) wait_idle();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();
      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
